regfile_sb: RTL and testbench

//   Parametrised dual-write, dual-read register file with a per-register busy scoreboard.

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two writeback ports, two read ports, issue strobe and scoreboard outputs.
interface regfile_sb_if #(
   parameter int DW = 32,
   parameter int AW = 5
) ();
   logic          we0;
   logic [AW-1:0] wn0;
   logic [DW-1:0] d0;
   logic          we1;
   logic [AW-1:0] wn1;
   logic [DW-1:0] d1;
   logic [AW-1:0] rna;
   logic [AW-1:0] rnb;
   logic [DW-1:0] qa;
   logic [DW-1:0] qb;
   logic          iss_vld;
   logic [AW-1:0] iss_rd;
   logic          busy_a;
   logic          busy_b;
   logic [AW:0]   busy_cnt;

   modport master (
      output we0, wn0, d0, we1, wn1, d1, rna, rnb, iss_vld, iss_rd,
      input  qa, qb, busy_a, busy_b, busy_cnt
   );

   modport slave (
      input  we0, wn0, d0, we1, wn1, d1, rna, rnb, iss_vld, iss_rd,
      output qa, qb, busy_a, busy_b, busy_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with per-register busy scoreboard and registered busy count.
// Optional macro REGFILE_SB_BYPASS_EN adds same-cycle write-to-read forwarding on qa/qb/busy_a/busy_b.
module regfile_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_sb_if.slave bus
);
   localparam int NREG = 2**AW;
   localparam int LO   = (ZERO_REG != 0) ? 1 : 0;

   logic [DW-1:0]   mem [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     cnt_q;
   logic [AW:0]     cnt_nxt;

   // Issue beats writeback on the same register: the new producer owns it.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      for (int r = 0; r < NREG; r++) begin
         if (bus.iss_vld && bus.iss_rd == AW'(r))
            busy_nxt[r] = 1'b1;
         else if ((bus.we0 && bus.wn0 == AW'(r)) || (bus.we1 && bus.wn1 == AW'(r)))
            busy_nxt[r] = 1'b0;
      end
      if (ZERO_REG != 0)
         busy_nxt[0] = 1'b0;
      for (int r = 0; r < NREG; r++)
         cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= '0;
         cnt_q <= '0;
      end else begin
         busy  <= busy_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   // Port 1 is checked first so it wins a same-register collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++)
            mem[r] <= '0;
      end else begin
         for (int r = LO; r < NREG; r++) begin
            if (bus.we1 && bus.wn1 == AW'(r))
               mem[r] <= bus.d1;
            else if (bus.we0 && bus.wn0 == AW'(r))
               mem[r] <= bus.d0;
         end
      end
   end

   logic [AW-1:0] rn  [2];
   logic [DW-1:0] q   [2];
   logic          bsy [2];

   assign rn[0] = bus.rna;
   assign rn[1] = bus.rnb;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         q[p]   = mem[rn[p]];
         bsy[p] = busy[rn[p]];
`ifdef REGFILE_SB_BYPASS_EN
         if (bus.we1 && bus.wn1 == rn[p])
            q[p] = bus.d1;
         else if (bus.we0 && bus.wn0 == rn[p])
            q[p] = bus.d0;
         if (((bus.we0 && bus.wn0 == rn[p]) || (bus.we1 && bus.wn1 == rn[p])) &&
             !(bus.iss_vld && bus.iss_rd == rn[p]))
            bsy[p] = 1'b0;
`endif
         if (ZERO_REG != 0 && rn[p] == '0) begin
            q[p]   = '0;
            bsy[p] = 1'b0;
         end
      end
   end

   assign bus.qa       = q[0];
   assign bus.qb       = q[1];
   assign bus.busy_a   = bsy[0];
   assign bus.busy_b   = bsy[1];
   assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, corner sequences, randomized run vs. reference model.
module tb_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   regfile_sb_if #(.DW(DW), .AW(AW)) bus ();
   regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference state: register contents and the set of busy registers.
   logic [31:0] m_reg  [NR];
   bit          m_busy [NR];

   function automatic void model_reset();
      for (int r = 0; r < NR; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      if (bus.we0) m_reg[bus.wn0] = bus.d0;
      if (bus.we1) m_reg[bus.wn1] = bus.d1;
      if (bus.we0) m_busy[bus.wn0] = 1'b0;
      if (bus.we1) m_busy[bus.wn1] = 1'b0;
      if (bus.iss_vld) m_busy[bus.iss_rd] = 1'b1;
      m_reg[0]  = '0;
      m_busy[0] = 1'b0;
   endfunction

   function automatic int m_cnt();
      int n = 0;
      for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   function automatic logic [31:0] exp_q(input logic [4:0] rn);
      logic [31:0] v = m_reg[rn];
`ifdef REGFILE_SB_BYPASS_EN
      if (bus.we1 && bus.wn1 == rn) v = bus.d1;
      else if (bus.we0 && bus.wn0 == rn) v = bus.d0;
`endif
      if (rn == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_b(input logic [4:0] rn);
      logic b = m_busy[rn];
`ifdef REGFILE_SB_BYPASS_EN
      if (((bus.we0 && bus.wn0 == rn) || (bus.we1 && bus.wn1 == rn)) &&
          !(bus.iss_vld && bus.iss_rd == rn))
         b = 1'b0;
`endif
      if (rn == 0) b = 1'b0;
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.we0 = 0; bus.wn0 = '0; bus.d0 = '0;
      bus.we1 = 0; bus.wn1 = '0; bus.d1 = '0;
      bus.iss_vld = 0; bus.iss_rd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [4:0] rnd_rn();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   typedef struct {
      logic        we0; logic [4:0] wn0; logic [31:0] d0;
      logic        we1; logic [4:0] wn1; logic [31:0] d1;
      logic        iss; logic [4:0] ird;
      logic [4:0]  rn;  logic [31:0] eq; logic eb; logic [5:0] ec;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 32'h22, 0, 0};
      tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 3, 3, 32'h0, 1, 1};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 4, 4, 32'h0, 1, 2};
      tbl[3] = '{0, 0, 0, 1, 3, 32'h9, 1, 3, 3, 32'h9, 1, 2};
      tbl[4] = '{1, 4, 32'h44, 0, 0, 0, 0, 0, 4, 32'h44, 0, 1};
      tbl[5] = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 32'h0, 0, 1};
      tbl[6] = '{0, 0, 0, 1, 3, 32'h5, 0, 0, 3, 32'h5, 0, 0};
      tbl[7] = '{1, 9, 32'hABC, 0, 0, 0, 0, 0, 9, 32'hABC, 0, 0};

      idle();
      bus.rna = '0; bus.rnb = '0;
      model_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      bus.rna = 5'd7; bus.rnb = 5'd31;
      #1;
      chk("reset_qa", bus.qa, 0);
      chk("reset_qb", bus.qb, 0);
      chk("reset_cnt", bus.busy_cnt, 0);

      // Directed table: apply one op for a cycle, then read back with the bus idle.
      for (int i = 0; i < 8; i++) begin
         bus.we0 = tbl[i].we0; bus.wn0 = tbl[i].wn0; bus.d0 = tbl[i].d0;
         bus.we1 = tbl[i].we1; bus.wn1 = tbl[i].wn1; bus.d1 = tbl[i].d1;
         bus.iss_vld = tbl[i].iss; bus.iss_rd = tbl[i].ird;
         tick();
         idle();
         bus.rna = tbl[i].rn; bus.rnb = tbl[i].rn;
         #1;
         chk($sformatf("tbl%0d_qa", i), bus.qa, tbl[i].eq);
         chk($sformatf("tbl%0d_qb", i), bus.qb, tbl[i].eq);
         chk($sformatf("tbl%0d_busy_a", i), bus.busy_a, tbl[i].eb);
         chk($sformatf("tbl%0d_cnt", i), bus.busy_cnt, tbl[i].ec);
      end

      // Writeback to busy r6 while reading it in the same cycle.
      bus.iss_vld = 1; bus.iss_rd = 5'd6;
      tick();
      idle();
      bus.rna = 5'd6;
      bus.we0 = 1; bus.wn0 = 5'd6; bus.d0 = 32'h1234;
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk("byp_same_qa", bus.qa, 32'h1234);
      chk("byp_same_busy", bus.busy_a, 0);
`else
      chk("byp_same_qa", bus.qa, 32'h0);
      chk("byp_same_busy", bus.busy_a, 1);
`endif
      tick();
      idle();
      #1;
      chk("byp_next_qa", bus.qa, 32'h1234);
      chk("byp_next_busy", bus.busy_a, 0);

      // Fill the scoreboard, re-issue one, then drain with both ports.
      for (int r = 1; r < NR; r++) begin
         bus.iss_vld = 1; bus.iss_rd = 5'(r);
         tick();
      end
      idle();
      #1;
      chk("fill_cnt", bus.busy_cnt, 31);
      bus.iss_vld = 1; bus.iss_rd = 5'd5;
      tick();
      idle();
      #1;
      chk("fill_reissue_cnt", bus.busy_cnt, 31);
      for (int r = 1; r < NR; r += 2) begin
         bus.we0 = 1; bus.wn0 = 5'(r); bus.d0 = 32'(r);
         bus.we1 = (r + 1 < NR); bus.wn1 = 5'(r + 1); bus.d1 = 32'(r + 1);
         tick();
      end
      idle();
      #1;
      chk("drain_cnt", bus.busy_cnt, 0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         bus.we0 = 1'($urandom_range(0, 1)); bus.wn0 = rnd_rn(); bus.d0 = $urandom;
         bus.we1 = 1'($urandom_range(0, 1)); bus.wn1 = rnd_rn(); bus.d1 = $urandom;
         bus.iss_vld = 1'($urandom_range(0, 1)); bus.iss_rd = rnd_rn();
         bus.rna = rnd_rn(); bus.rnb = rnd_rn();
         #1;
         chk("rnd_qa", bus.qa, exp_q(bus.rna));
         chk("rnd_qb", bus.qb, exp_q(bus.rnb));
         chk("rnd_busy_a", bus.busy_a, exp_b(bus.rna));
         chk("rnd_busy_b", bus.busy_b, exp_b(bus.rnb));
         chk("rnd_cnt", bus.busy_cnt, 64'(m_cnt()));
         tick();
      end

      // Mid-cycle asynchronous reset with r5 written and registers busy.
      idle();
      bus.we0 = 1; bus.wn0 = 5'd5; bus.d0 = 32'hA5A5_A5A5;
      bus.iss_vld = 1; bus.iss_rd = 5'd9;
      tick();
      idle();
      bus.rna = 5'd5;
      #1;
      chk("pre_rst_qa", bus.qa, 32'hA5A5_A5A5);
      #1 rst_n = 0;
      #1;
      chk("rst_qa", bus.qa, 0);
      chk("rst_cnt", bus.busy_cnt, 0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1;
      bus.rna = 5'd9;
      #1;
      chk("rst_busy_a", bus.busy_a, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
